// File: rtl/gmii_mac_rx.sv
// gmii_mac_rx -- GbE receive MAC front end.
// Registers the GMII byte stream, hunts for preamble (0x55...) + SFD (0xD5),
// and forwards every post-SFD byte (FCS kept) on an AXI4-Stream master that
// has no backpressure. tuser on the tlast beat flags a CRC-32 residue mismatch
// (when CHECK_FCS) or an oversize frame.
//
// Ports:
//   rx_clk         GMII receive clock (125 MHz), rising edge only
//   rst            asynchronous active-high reset
//   gmii_rxd       GMII receive byte
//   gmii_rx_dv     GMII data valid
//   m_axis_tdata   frame byte
//   m_axis_tvalid  beat valid (sink must always accept)
//   m_axis_tlast   last byte of frame
//   m_axis_tuser   frame error, only ever high together with tvalid & tlast
module gmii_mac_rx #(
  parameter int MAX_LEN   = 1522,
  parameter bit CHECK_FCS = 1'b1
) (
  input  logic       rx_clk,
  input  logic       rst,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser
);

  localparam int          CW      = $clog2(MAX_LEN + 1);
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_t;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic       l;
    logic       u;
  } beat_t;

  // Reflected CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  state_t        state, state_n;
  logic [7:0]    rxd_q;
  logic          dv_q;
  logic [7:0]    hold, hold_n;
  logic          hold_vld, hold_vld_n;
  logic          hold_ovf, hold_ovf_n;   // held byte is the MAX_LEN-th one
  logic [31:0]   crc, crc_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  beat_t         beat_n;

  assign cnt_inc = cnt + CW'(1);

  always_comb begin
    state_n    = state;
    hold_n     = hold;
    hold_vld_n = hold_vld;
    hold_ovf_n = hold_ovf;
    crc_n      = crc;
    cnt_n      = cnt;
    beat_n     = '0;
    case (state)
      IDLE: begin
        if (dv_q) state_n = (rxd_q == 8'h55) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!dv_q) begin
          state_n = IDLE;
        end else if (rxd_q == 8'hD5) begin
          state_n    = PAYLOAD;
          crc_n      = '1;
          cnt_n      = '0;
          hold_vld_n = 1'b0;
          hold_ovf_n = 1'b0;
        end else if (rxd_q != 8'h55) begin
          state_n = DROP;
        end
      end
      PAYLOAD: begin
        if (hold_vld && hold_ovf) begin
          // Truncate: the MAX_LEN-th byte closes the frame as an error and
          // whatever is still arriving is discarded.
          beat_n     = '{d: hold, v: 1'b1, l: 1'b1, u: 1'b1};
          hold_vld_n = 1'b0;
          state_n    = dv_q ? DROP : IDLE;
        end else if (dv_q) begin
          // The held byte can only be known non-last once a successor shows up.
          if (hold_vld) beat_n = '{d: hold, v: 1'b1, l: 1'b0, u: 1'b0};
          hold_n     = rxd_q;
          hold_vld_n = 1'b1;
          hold_ovf_n = (cnt_inc == CW'(MAX_LEN));
          crc_n      = crc_byte(crc, rxd_q);
          cnt_n      = cnt_inc;
        end else begin
          if (hold_vld)
            beat_n = '{d: hold, v: 1'b1, l: 1'b1, u: CHECK_FCS ? (crc != RESIDUE) : 1'b0};
          hold_vld_n = 1'b0;
          state_n    = IDLE;
        end
      end
      DROP: begin
        if (!dv_q) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // dv_q resets to 1 so the first post-reset decision is always DROP: if the
  // PHY is mid-frame we wait for dv low, otherwise it costs a single idle cycle.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rxd_q         <= '0;
      dv_q          <= 1'b1;
      hold          <= '0;
      hold_vld      <= 1'b0;
      hold_ovf      <= 1'b0;
      crc           <= '1;
      cnt           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      state         <= state_n;
      rxd_q         <= gmii_rxd;
      dv_q          <= gmii_rx_dv;
      hold          <= hold_n;
      hold_vld      <= hold_vld_n;
      hold_ovf      <= hold_ovf_n;
      crc           <= crc_n;
      cnt           <= cnt_n;
      m_axis_tdata  <= beat_n.d;
      m_axis_tvalid <= beat_n.v;
      m_axis_tlast  <= beat_n.l;
      m_axis_tuser  <= beat_n.u;
    end
  end

endmodule

// File: tb/tb_gmii_mac_rx.sv
// Directed bench for gmii_mac_rx (MAX_LEN=64). Stimulus pushes expected beats
// into exp_q; an independent monitor pops and compares on every tvalid.
module tb_gmii_mac_rx;

  logic       rx_clk = 1'b0;
  logic       rst;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser;

  gmii_mac_rx #(.MAX_LEN(64), .CHECK_FCS(1'b1)) dut (
    .rx_clk        (rx_clk),
    .rst           (rst),
    .gmii_rxd      (gmii_rxd),
    .gmii_rx_dv    (gmii_rx_dv),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser)
  );

  always #4 rx_clk = ~rx_clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] pay[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         t_first = 0;
  bit         lat_arm = 1'b0;

  always @(posedge rx_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge.
  always @(negedge rx_clk) begin
    if (!rst) begin
      if (m_axis_tvalid) begin
        if (lat_arm) begin
          lat_arm = 1'b0;
          chk("first_latency_le3", 32'((cyc - t_first) >= 2 && (cyc - t_first) <= 3), 32'd1);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h last %0b user %0b, expected no beat",
                   m_axis_tdata, m_axis_tlast, m_axis_tuser);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("tdata", 32'(m_axis_tdata), 32'(e.d));
          chk("tlast", 32'(m_axis_tlast), 32'(e.l));
          chk("tuser", 32'(m_axis_tuser), 32'(e.u));
        end
      end else begin
        chk("idle_last_user", 32'({m_axis_tlast, m_axis_tuser}), 32'd0);
      end
    end
  end

  task automatic drive(input logic dv, input logic [7:0] d);
    @(negedge rx_clk);
    gmii_rx_dv = dv;
    gmii_rxd   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  // 7x preamble + SFD + pay, then `gap` idle cycles. Expected beats are
  // queued up front when `emit` is set.
  task automatic frame(input bit emit, input bit exp_user, input int gap, input bit meas);
    if (emit)
      for (int i = 0; i < pay.size(); i++)
        exp_q.push_back('{d: pay[i], l: (i == pay.size() - 1),
                          u: (i == pay.size() - 1) && exp_user});
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < pay.size(); i++) begin
      drive(1'b1, pay[i]);
      if (i == 0 && meas) begin
        t_first = cyc;
        lat_arm = 1'b1;
      end
    end
    idle(gap);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge rx_clk);
      n++;
    end
    idle(4);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_check_frame(input bit corrupt);
    pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    if (corrupt) pay[0] = 8'h30;
  endtask

  initial begin
    rst        = 1'b1;
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    repeat (3) @(negedge rx_clk);
    chk("reset_outputs", 32'({m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser}), 32'd0);
    rst = 1'b0;
    idle(4);

    // HELLO_FPGA, no valid FCS
    pay = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h5F, 8'h46, 8'h50, 8'h47, 8'h41};
    frame(1'b1, 1'b1, 3, 1'b1);
    drain("drain_hello");

    // "123456789" + correct FCS, then corrupted copy back-to-back (1-cycle gap)
    set_check_frame(1'b0);
    frame(1'b1, 1'b0, 1, 1'b0);
    set_check_frame(1'b1);
    frame(1'b1, 1'b1, 3, 1'b0);
    drain("drain_crc");

    // Burst without preamble, then a good frame after a 1-cycle gap
    drive(1'b1, 8'hAA);
    drive(1'b1, 8'h11);
    drive(1'b1, 8'hD5);
    drive(1'b1, 8'h22);
    idle(1);
    set_check_frame(1'b0);
    frame(1'b1, 1'b0, 3, 1'b0);
    drain("drain_nopre");

    // Oversize: 74 bytes -> 64 beats, last flagged; rest discarded
    pay.delete();
    for (int i = 0; i < 74; i++) pay.push_back(8'(i + 8'h80));
    for (int i = 0; i < 64; i++)
      exp_q.push_back('{d: pay[i], l: (i == 63), u: (i == 63)});
    frame(1'b0, 1'b0, 3, 1'b0);
    drain("drain_oversize");
    set_check_frame(1'b0);
    frame(1'b1, 1'b0, 3, 1'b0);
    drain("drain_after_oversize");

    // Reset during 5th payload byte, released while dv still high
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    exp_q.push_back('{d: 8'h10, l: 1'b0, u: 1'b0});
    exp_q.push_back('{d: 8'h11, l: 1'b0, u: 1'b0});
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h10 + i));
    #1 rst = 1'b1;
    #1 chk("midframe_reset_outputs",
           32'({m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser}), 32'd0);
    drive(1'b1, 8'h15);
    drive(1'b1, 8'h16);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h17 + i));
    idle(2);
    drain("drain_reset");
    set_check_frame(1'b0);
    frame(1'b1, 1'b0, 3, 1'b0);
    drain("drain_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
